// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

  // Index of the final byte of an access; size 2'b11 falls through to word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_sequencer.sv
// Byte-serial big-endian transfer engine: byte counter, address wrap,
// read shift register, store byte select and load extension.
module mem_byte_sequencer
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          Clk,
  input  logic          R,
  input  logic          start,
  input  logic          xfer,
  input  logic [AW-1:0] addr,
  input  logic          rw,
  input  logic [1:0]    size,
  input  logic          se,
  input  logic [31:0]   wdata,
  input  logic [7:0]    mem_rdata,
  output logic          last,
  output logic          rd_last,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  output logic [31:0]   ld_data
);

  logic [1:0]    idx_q;
  logic [AW-1:0] base_q;
  logic          rw_q;
  logic [1:0]    size_q;
  logic          se_q;
  logic [31:0]   wdata_q;
  logic [23:0]   sreg_q;
  logic [1:0]    bsel;

  function automatic logic [31:0] extend(input logic [31:0] raw,
                                         input logic [1:0]  sz,
                                         input logic        sx);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = raw[7:0];
    h = raw[15:0];
    case (sz)
      SZ_BYTE: return sx ? 32'(b) : {24'd0, raw[7:0]};
      SZ_HALF: return sx ? 32'(h) : {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      idx_q   <= '0;
      base_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      se_q    <= 1'b0;
      wdata_q <= '0;
      sreg_q  <= '0;
    end else if (start) begin
      idx_q   <= '0;
      base_q  <= addr;
      rw_q    <= rw;
      size_q  <= size;
      se_q    <= se;
      wdata_q <= wdata;
      sreg_q  <= '0;
    end else if (xfer) begin
      idx_q <= idx_q + 2'd1;
      if (!rw_q) sreg_q <= {sreg_q[15:0], mem_rdata};
    end
  end

  // Shift register is cleared at grant, so short loads arrive zero-padded.
  assign last      = xfer && (idx_q == last_idx(size_q));
  assign rd_last   = last && !rw_q;
  assign bsel      = last_idx(size_q) - idx_q;
  assign mem_addr  = xfer ? base_q + {{(AW-2){1'b0}}, idx_q} : '0;
  assign mem_we    = xfer && rw_q;
  assign mem_wdata = (xfer && rw_q) ? wdata_q[{bsel, 3'b000} +: 8] : 8'd0;
  assign ld_data   = extend({sreg_q, mem_rdata}, size_q, se_q);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory between instruction fetch and data access.
// Define ARB_RR_EN for round-robin priority; default is data-over-fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          Clk,
  input  logic          R,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_ready,
  output logic [31:0]   if_data,
  input  logic          dm_req,
  input  logic          dm_rw,
  input  logic [1:0]    dm_size,
  input  logic          dm_se,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_ready,
  output logic [31:0]   dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          pipe_stall
);

  state_t        state_q, state_d;
  gnt_t          gnt_q, pick;
  logic          start, xfer, last, rd_last;
  logic [AW-1:0] sel_addr;
  logic          sel_rw, sel_se;
  logic [1:0]    sel_size;
  logic [31:0]   ld_data;
  logic          unused_hi;

  assign unused_hi = ^{if_addr[31:AW], dm_addr[31:AW]};

`ifdef ARB_RR_EN
  // gnt_q doubles as the last-grant record; its reset value is GNT_IF.
  always_comb begin
    pick = GNT_IF;
    if (dm_req && if_req) pick = (gnt_q == GNT_DM) ? GNT_IF : GNT_DM;
    else if (dm_req)      pick = GNT_DM;
  end
`else
  always_comb begin
    pick = GNT_IF;
    if (dm_req) pick = GNT_DM;
  end
`endif

  assign sel_addr = (pick == GNT_DM) ? dm_addr[AW-1:0] : if_addr[AW-1:0];
  assign sel_rw   = (pick == GNT_DM) ? dm_rw : 1'b0;
  assign sel_size = (pick == GNT_DM) ? dm_size : SZ_WORD;
  assign sel_se   = (pick == GNT_DM) ? dm_se : 1'b0;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          start   = 1'b1;
          state_d = XFER;
        end
      end
      XFER:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state_q  <= IDLE;
      gnt_q    <= GNT_IF;
      if_data  <= '0;
      dm_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (start) gnt_q <= pick;
      if (rd_last) begin
        if (gnt_q == GNT_DM) dm_rdata <= ld_data;
        else                 if_data  <= ld_data;
      end
    end
  end

  assign xfer       = (state_q == XFER);
  assign mem_en     = xfer;
  assign if_ready   = (state_q == DONE) && (gnt_q == GNT_IF);
  assign dm_ready   = (state_q == DONE) && (gnt_q == GNT_DM);
  assign pipe_stall = (if_req && !if_ready) || (dm_req && !dm_ready);

  mem_byte_sequencer #(.AW(AW)) u_seq (
    .Clk       (Clk),
    .R         (R),
    .start     (start),
    .xfer      (xfer),
    .addr      (sel_addr),
    .rw        (sel_rw),
    .size      (sel_size),
    .se        (sel_se),
    .wdata     (dm_wdata),
    .mem_rdata (mem_rdata),
    .last      (last),
    .rd_last   (rd_last),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .ld_data   (ld_data)
  );

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one byte-wide unified memory array (Mem[0:2^AW-1]) between the IF-stage instruction fetch and the MEM-stage data access (load/store).
- Serialises each word or halfword into one byte per cycle, big-endian (lowest address = MSB).
- Applies sign or zero extension on loads.
- Produces a stall indication for the PC, nPC and pipeline-register load enables.

Parameters:
AW, 9, memory address width in bytes (512-byte array)

Ports:
Clk  in  1  system clock, rising edge
R  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request; held until if_ready
if_addr  in  32  fetch byte address
if_ready  out  1  one-cycle pulse, fetch complete
if_data  out  32  fetched instruction; valid while if_ready=1
dm_req  in  1  data request; held until dm_ready
dm_rw  in  1  0=load, 1=store
dm_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
dm_se  in  1  sign-extend load result
dm_addr  in  32  data byte address
dm_wdata  in  32  store data, right-aligned
dm_ready  out  1  one-cycle pulse, data access complete
dm_rdata  out  32  load result; valid while dm_ready=1
mem_en  out  1  memory byte access this cycle
mem_we  out  1  byte write strobe
mem_addr  out  AW  byte address
mem_wdata  out  8  write byte
mem_rdata  in  8  read byte, combinational from mem_addr
pipe_stall  out  1  (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational

Behaviour:
- Reset (R=0) forces these outputs to 0 immediately, regardless of clock: state, byte counter, shift register, if_ready, dm_ready, if_data, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata.
- FSM states:
  - IDLE: samples requests. If one is pending, latches grant, address, rw, size, se and wdata, loads idx=0, and moves to XFER. Otherwise stays in IDLE.
  - XFER: drives mem_en=1 and mem_addr = (base+idx) mod 2^AW.
    - Load: shifts mem_rdata into the shift register at the clock edge.
    - Store: drives mem_we=1 and mem_wdata = byte (n-1-idx) of wdata.
    - Increments idx each cycle; after byte n-1, moves to DONE.
  - DONE: pulses the granted ready for exactly one cycle with data valid, then returns to IDLE.
- Byte counts: n = 1, 2 or 4. A fetch is always a read of n=4.
- Latency: request sampled in IDLE at cycle 0, bytes transferred in cycles 1..n, ready in cycle n+1. A word access has ready in cycle 5.
- There is always at least one IDLE cycle between transactions.
- Priority: if both requests are pending in IDLE, dm wins, because the MEM-stage instruction is older.
- Load extension:
  - Byte: dm_se=1 replicates bit 7; otherwise upper bits are 0.
  - Halfword: dm_se=1 replicates bit 15; otherwise upper bits are 0.
  - Word: dm_se is ignored.
- Alignment is not checked. Misaligned accesses proceed byte-by-byte, with the address wrapping modulo 2^AW.
- Address bits above AW are ignored.
- Requester protocol violations:
  - Dropping req mid-transfer does not abort; the transaction completes and ready still pulses.
  - Changing fields after grant has no effect.
- Reset mid-transfer aborts immediately. Store bytes already written remain in memory; no ready is issued.
- if_data and dm_rdata hold their last value after the ready pulse.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin priority. A last-grant bit (reset value = fetch granted) gives priority to the requester not granted last, whenever both are pending.
- Undefined: fixed dm-over-fetch priority; no last-grant state.

Decomposition:
- Shared package holds:
  - state enum {IDLE, XFER, DONE}
  - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - grant encoding GNT_IF / GNT_DM
- One sub-module, mem_byte_sequencer, owns:
  - the byte counter
  - the address increment/wrap
  - the read shift register and write byte select
  - the extension logic
- mem_port_arbiter keeps the FSM, grant logic and ready/stall outputs.

Test Plan:
1. Preload 0x10..0x13 = 80,12,34,56; fetch 0x10 -> if_ready in cycle 5, if_data=0x80123456, mem_we never asserted.
2. Byte load at 0x10 with dm_se=1 -> dm_ready in cycle 2, dm_rdata=0xFFFFFF80. Repeat with dm_se=0 -> 0x00000080.
3. Halfword store 0x20 with wdata=0x0000ABCD -> mem_we high for 2 cycles, Mem[0x20]=AB, Mem[0x21]=CD. Then halfword load with se=1 -> 0xFFFFABCD.
4. if_req and dm_req (word load) both asserted in cycle 0 -> dm_ready in cycle 5, IDLE in cycle 6, if_ready in cycle 11, pipe_stall=1 in cycles 0-10. With ARB_RR_EN, a repeated simultaneous request grants fetch first.
5. Word store 0x11223344 to 0x30; R driven low mid cycle 3 -> outputs 0 immediately, no dm_ready. Mem[0x30]=11 and Mem[0x31]=22; 0x32 and 0x33 are unchanged.
6. AW=9 word load at 0x1FE -> mem_addr sequence 0x1FE, 0x1FF, 0x000, 0x001; dm_rdata assembled in that byte order.
